alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Sequential front end for `alu32`. It accepts one register-register or register-immediate instruction per handshake and reads operands from an internal 32x32 register file. It drives `alu32`'s operand and control inputs, captures the ALU result and flags, writes the result back, and maintains an architectural NZV status register. It sits directly upstream of `alu32` and closes the write-back loop around it.

## Interface
Parameters:
- NREGS, 32, register count; address width is fixed at 5 bits.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  instruction present.
- in_ready  out  1  unit can accept an instruction.
- in_op  in  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1001 NOR, 1100 NAND, 1101 XOR.
- in_rd, in_rs, in_rt  in  5 each  destination, source 1 and source 2 register indices.
- in_imm_sel  in  1  when 1, op2 = in_imm instead of reg[rt].
- in_imm  in  32  immediate operand.
- alu_op1, alu_op2  out  32 each  to the `alu32` operands.
- alu_ctrl  out  4  to the `alu32` control code.
- alu_result  in  32  from `alu32`.
- alu_v, alu_n, alu_z  in  1 each  flags from `alu32`.
- wb_valid  out  1  one-cycle write-back strobe.
- wb_rd  out  5  write-back register index.
- wb_data  out  32  write-back data.
- status_nzv  out  3  {N,Z,V} architectural flags.
- err  out  1  one-cycle pulse on an illegal opcode.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  combinational reg[dbg_addr].

## Operation
- FSM states: IDLE, EXEC, WB. in_ready = 1 only in IDLE.
- IDLE: on in_valid && in_ready, latch op, rd, rs, rt, imm_sel and imm. Next state is EXEC. Otherwise stay in IDLE.
- EXEC:
  - alu_op1 = reg[rs].
  - alu_op2 = imm_sel ? imm : reg[rt].
  - alu_ctrl = op.
  - At the end of the cycle, capture alu_result, alu_n, alu_z and alu_v into holding registers. Next state is WB.
- WB:
  - wb_valid = 1 and wb_data = captured result, unless the opcode is illegal.
  - At the end of the cycle:
    - Write reg[rd] unless rd == 0.
    - For ADD or SUB only, status_nzv <= captured {N,Z,V}.
    - Logic ops leave status_nzv unchanged.
  - Next state is IDLE.
- Register 0 always reads 0. Writes to register 0 are discarded, but wb_valid still pulses with wb_rd = 0.
- Illegal opcode (any code not listed):
  - The instruction is still accepted and sequenced through EXEC and WB.
  - In WB: wb_valid = 0, err = 1, no register write, no status update.
- Outside EXEC, alu_op1, alu_op2 and alu_ctrl are driven 0. Outside WB, wb_valid, wb_rd, wb_data and err are 0.
- Reads in EXEC always see all prior write-backs, because execution is strictly serialized. No forwarding is needed.
- Reset (rst_n = 0 at a clock edge), including mid-instruction:
  - State returns to IDLE and any in-flight instruction is dropped with no write-back.
  - All registers and status_nzv are cleared to 0.

## Timing
- Reset values: in_ready = 1 (once rst_n is released), all other outputs 0, all registers 0.
- Accept at edge T0 → EXEC during cycle T0–T1 → WB during T1–T2, with wb_valid high → register file and status updated at edge T2.
- Earliest next accept is at edge T3 (back in IDLE during T2–T3). Throughput is one instruction per 3 cycles.
- in_valid is ignored when in_ready = 0. A holding upstream may keep in_valid asserted; the instruction is taken at the next IDLE edge.
- `alu32` is combinational. Its outputs must settle within the EXEC cycle.
- dbg_data reflects a write in the cycle after edge T2.

## Test plan
- Reset, then ADD r1,r0,imm=10 and ADD r2,r0,imm=-10 → dbg r1 = 0000000A, r2 = FFFFFFF6. Each wb_valid pulse is exactly 1 cycle, 2 cycles after accept.
- SUB r3,r1,r1 → r3 = 0, status_nzv = 010. Then SUB r4,r2,r1 → r4 = -20, status_nzv = 100.
- Load r5 = 0000FFFF and r6 = 00FF00FF, then AND, OR, NOR, XOR, NAND into r7..r11. Expected results: 000000FF, 00FFFFFF, FF000000, 00FFFF00, FFFFFF00. status_nzv is unchanged across all five.
- Load r1 = 7FFFFFFF, then ADD r2,r1,r1 → r2 = FFFFFFFE, status_nzv = 101. Then SUB with imm 80000000 from r0 → V = 1.
- ADD r0,r1,r1 → r0 stays 0 and wb_valid pulses. Opcode 0111 → err pulses, no write, status unchanged.
- Assert in_valid continuously → accepts occur every 3 cycles. Drive rst_n low during EXEC → no write-back, in_ready = 1 after release, all registers read 0.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Serialized issue/write-back front end for alu32.
// Owns the register file and the architectural NZV flags.
module alu_issue_unit #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic        in_imm_sel,
  input  logic [31:0] in_imm,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [2:0]  status_nzv,
  output logic        err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic        imm_sel_q;
  logic [31:0] imm_q;
  logic [31:0] res_q;
  logic        n_q;
  logic        z_q;
  logic        v_q;
  logic [2:0]  nzv_q;
  logic [31:0] regs [NREGS];

  logic        legal;
  logic        arith;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB,
      OP_NOR, OP_NAND, OP_XOR: is_legal = 1'b1;
      default:                 is_legal = 1'b0;
    endcase
  endfunction

  // r0 and out-of-range indices read as zero
  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0 || 32'(a) >= NREGS)
      rf_read = '0;
    else
      rf_read = regs[a];
  endfunction

  assign legal = is_legal(op_q);
  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = '0;
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    err      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      EXEC: begin
        alu_op1  = rf_read(rs_q);
        alu_op2  = imm_sel_q ? imm_q : rf_read(rt_q);
        alu_ctrl = op_q;
      end
      WB: begin
        if (legal) begin
          wb_valid = 1'b1;
          wb_rd    = rd_q;
          wb_data  = res_q;
        end else begin
          err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
      res_q     <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
      nzv_q     <= '0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        op_q      <= in_op;
        rd_q      <= in_rd;
        rs_q      <= in_rs;
        rt_q      <= in_rt;
        imm_sel_q <= in_imm_sel;
        imm_q     <= in_imm;
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        n_q   <= alu_n;
        z_q   <= alu_z;
        v_q   <= alu_v;
      end
      if (state == WB && legal) begin
        if (rd_q != 5'd0 && 32'(rd_q) < NREGS)
          regs[rd_q] <= res_q;
        if (arith)
          nzv_q <= {n_q, z_q, v_q};
      end
    end
  end

  assign status_nzv = nzv_q;
  assign dbg_data   = rf_read(dbg_addr);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioral alu32.
// Expected values are hand-computed constants.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic        in_imm_sel;
  logic [31:0] in_imm;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_v;
  logic        alu_n;
  logic        alu_z;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  status_nzv;
  logic        err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_chk;
  int n_err;

  localparam logic [3:0] AND_ = 4'b0000;
  localparam logic [3:0] OR_  = 4'b0001;
  localparam logic [3:0] ADD_ = 4'b0010;
  localparam logic [3:0] SUB_ = 4'b0110;
  localparam logic [3:0] NOR_ = 4'b1001;
  localparam logic [3:0] NAND = 4'b1100;
  localparam logic [3:0] XOR_ = 4'b1101;

  alu_issue_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_imm_sel (in_imm_sel),
    .in_imm     (in_imm),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_v      (alu_v),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .status_nzv (status_nzv),
    .err        (err),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu32 stand-in
  always_comb begin
    alu_result = '0;
    alu_v      = 1'b0;
    case (alu_ctrl)
      AND_: alu_result = alu_op1 & alu_op2;
      OR_:  alu_result = alu_op1 | alu_op2;
      NOR_: alu_result = ~(alu_op1 | alu_op2);
      NAND: alu_result = ~(alu_op1 & alu_op2);
      XOR_: alu_result = alu_op1 ^ alu_op2;
      ADD_: begin
        alu_result = alu_op1 + alu_op2;
        alu_v = (alu_op1[31] == alu_op2[31]) &&
                (alu_result[31] != alu_op1[31]);
      end
      SUB_: begin
        alu_result = alu_op1 - alu_op2;
        alu_v = (alu_op1[31] != alu_op2[31]) &&
                (alu_result[31] != alu_op1[31]);
      end
      default: alu_result = '0;
    endcase
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'd0);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag,
                        input logic [4:0] a,
                        input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic issue(input string tag,
                       input logic [3:0] op,
                       input logic [4:0] rd,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic sel,
                       input logic [31:0] imm,
                       input logic ok,
                       input logic [31:0] exp);
    int n;
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_rs      = rs;
    in_rt      = rt;
    in_imm_sel = sel;
    in_imm     = imm;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_exec_wbv"}, 32'(wb_valid), 32'd0);
    chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(op));
    @(posedge clk);
    #1;
    chk({tag, "_wbv"}, 32'(wb_valid), 32'(ok));
    chk({tag, "_err"}, 32'(err), 32'(!ok));
    chk({tag, "_wbrd"}, 32'(wb_rd), ok ? 32'(rd) : 32'd0);
    chk({tag, "_wbd"}, wb_data, ok ? exp : 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_wbv_off"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    int acc;
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = '0;
    in_rd      = '0;
    in_rs      = '0;
    in_rt      = '0;
    in_imm_sel = 1'b0;
    in_imm     = '0;
    dbg_addr   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_nzv", 32'(status_nzv), 32'd0);
    chk("rst_op1", alu_op1, 32'd0);
    rd_chk("rst_r1", 5'd1, 32'd0);

    issue("add_r1", ADD_, 1, 0, 0, 1, 32'd10, 1, 32'h0000000A);
    rd_chk("r1", 5'd1, 32'h0000000A);
    issue("add_r2", ADD_, 2, 0, 0, 1, 32'hFFFFFFF6, 1, 32'hFFFFFFF6);
    rd_chk("r2", 5'd2, 32'hFFFFFFF6);
    chk("nzv_r2", 32'(status_nzv), 32'b100);

    issue("sub_r3", SUB_, 3, 1, 1, 0, 32'd0, 1, 32'd0);
    rd_chk("r3", 5'd3, 32'd0);
    chk("nzv_r3", 32'(status_nzv), 32'b010);
    issue("sub_r4", SUB_, 4, 2, 1, 0, 32'd0, 1, 32'hFFFFFFEC);
    rd_chk("r4", 5'd4, 32'hFFFFFFEC);
    chk("nzv_r4", 32'(status_nzv), 32'b100);

    issue("ld_r5", ADD_, 5, 0, 0, 1, 32'h0000FFFF, 1, 32'h0000FFFF);
    issue("ld_r6", ADD_, 6, 0, 0, 1, 32'h00FF00FF, 1, 32'h00FF00FF);
    chk("nzv_ld", 32'(status_nzv), 32'b000);
    issue("ld_r12", SUB_, 12, 0, 0, 1, 32'd1, 1, 32'hFFFFFFFF);
    chk("nzv_r12", 32'(status_nzv), 32'b100);
    issue("and", AND_, 7, 5, 6, 0, 32'd0, 1, 32'h000000FF);
    issue("or", OR_, 8, 5, 6, 0, 32'd0, 1, 32'h00FFFFFF);
    issue("nor", NOR_, 9, 5, 6, 0, 32'd0, 1, 32'hFF000000);
    issue("xor", XOR_, 10, 5, 6, 0, 32'd0, 1, 32'h00FFFF00);
    issue("nand", NAND, 11, 5, 6, 0, 32'd0, 1, 32'hFFFFFF00);
    rd_chk("r7", 5'd7, 32'h000000FF);
    rd_chk("r8", 5'd8, 32'h00FFFFFF);
    rd_chk("r9", 5'd9, 32'hFF000000);
    rd_chk("r10", 5'd10, 32'h00FFFF00);
    rd_chk("r11", 5'd11, 32'hFFFFFF00);
    chk("nzv_logic", 32'(status_nzv), 32'b100);

    issue("ld_max", ADD_, 1, 0, 0, 1, 32'h7FFFFFFF, 1, 32'h7FFFFFFF);
    chk("nzv_max", 32'(status_nzv), 32'b000);
    issue("add_ovf", ADD_, 2, 1, 1, 0, 32'd0, 1, 32'hFFFFFFFE);
    rd_chk("r2_ovf", 5'd2, 32'hFFFFFFFE);
    chk("nzv_addovf", 32'(status_nzv), 32'b101);
    issue("ld_one", ADD_, 16, 0, 0, 1, 32'd1, 1, 32'd1);
    chk("nzv_one", 32'(status_nzv), 32'b000);
    issue("sub_ovf", SUB_, 15, 0, 0, 1, 32'h80000000, 1, 32'h80000000);
    chk("nzv_subovf", 32'(status_nzv), 32'b101);

    issue("ld_one2", ADD_, 16, 0, 0, 1, 32'd1, 1, 32'd1);
    issue("add_r0", ADD_, 0, 1, 1, 0, 32'd0, 1, 32'hFFFFFFFE);
    rd_chk("r0", 5'd0, 32'd0);
    chk("nzv_r0", 32'(status_nzv), 32'b101);
    issue("illegal", 4'b0111, 5, 1, 1, 0, 32'd0, 0, 32'd0);
    rd_chk("r5_kept", 5'd5, 32'h0000FFFF);
    chk("nzv_illegal", 32'(status_nzv), 32'b101);

    // held in_valid: r13 += 1 on every accept
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = ADD_;
    in_rd      = 5'd13;
    in_rs      = 5'd13;
    in_rt      = 5'd0;
    in_imm_sel = 1'b1;
    in_imm     = 32'd1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) acc++;
      @(posedge clk);
      #1;
      if (i != 11) @(negedge clk);
    end
    in_valid = 1'b0;
    chk("held_accepts", 32'(acc), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    rd_chk("r13", 5'd13, 32'd4);

    // reset mid-instruction
    @(negedge clk);
    in_valid   = 1'b1;
    in_op      = ADD_;
    in_rd      = 5'd14;
    in_rs      = 5'd0;
    in_imm_sel = 1'b1;
    in_imm     = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    chk("mid_exec", 32'(alu_ctrl), 32'(ADD_));
    @(posedge clk);
    #1;
    chk("mid_wbv0", 32'(wb_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_wbv1", 32'(wb_valid), 32'd0);
    rst_n = 1'b1;
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_nzv", 32'(status_nzv), 32'd0);
    for (int r = 0; r < 32; r++)
      rd_chk("mid_reg", 5'(r), 32'd0);
    @(posedge clk);
    #1;
    chk("post_wbv", 32'(wb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
